// File: rtl/apb4_pkg.sv
// apb4_pkg
// Shared definitions for the APB4 completer:
//   apb_phase_e    - bus phase decoded from psel/penable
//   WCNT_W         - width of the access-phase wait counter
//   byte_shift     - log2 of the byte count of one data word
//   addr_to_index  - byte address -> register index
//   addr_aligned   - true when the address is word aligned
package apb4_pkg;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_phase_e;

  // Only 8/16/32/64-bit data words are meaningful; anything else is treated as 32.
  function automatic int unsigned byte_shift(input int unsigned data_width);
    int unsigned sh;
    case (data_width)
      32'd8:   sh = 0;
      32'd16:  sh = 1;
      32'd64:  sh = 3;
      default: sh = 2;
    endcase
    return sh;
  endfunction

  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input int unsigned data_width);
    return addr >> byte_shift(data_width);
  endfunction

  function automatic logic addr_aligned(input logic [63:0] addr,
                                        input int unsigned data_width);
    logic [63:0] mask;
    mask = (64'd1 << byte_shift(data_width)) - 64'd1;
    return (addr & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/apb4_protocol_checker.sv
// apb4_protocol_checker
// Decodes the current APB phase and keeps a sticky protocol-violation flag.
// Ports:
//   pclk, preset             - clock, synchronous active-high reset
//   psel, penable, pwrite    - bus control from the requester
//   paddr, pwdata            - bus address / write data (checked for stability)
//   pready                   - completer handshake of the current cycle
//   proto_err_clr            - clears the flag (a new violation wins)
//   phase                    - decoded phase of the current cycle
//   proto_err                - sticky violation flag
module apb4_protocol_checker
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  proto_err_clr,
  output apb_phase_e            phase,
  output logic                  proto_err
);

  apb_phase_e            prev_phase_q, prev_phase_d;
  logic                  prev_ready_q, prev_ready_d;
  logic                  prev_write_q, prev_write_d;
  logic [ADDR_WIDTH-1:0] prev_addr_q, prev_addr_d;
  logic [DATA_WIDTH-1:0] prev_wdata_q, prev_wdata_d;
  logic                  proto_err_q, proto_err_d;

  logic viol_setup_drop;
  logic viol_enable_nosel;
  logic viol_unstable;
  logic viol_no_setup;

  always_comb begin
    if (!psel) begin
      phase = APB_IDLE;
    end else if (!penable) begin
      phase = APB_SETUP;
    end else begin
      phase = APB_ACCESS;
    end
  end

  always_comb begin
    viol_setup_drop   = (prev_phase_q == APB_SETUP) && (phase != APB_ACCESS);
    viol_enable_nosel = penable && !psel;
    // A stalled access must hold its address, direction and data.
    viol_unstable     = (phase == APB_ACCESS) && (prev_phase_q == APB_ACCESS) && !prev_ready_q &&
                        ((paddr != prev_addr_q) || (pwrite != prev_write_q) ||
                         (pwdata != prev_wdata_q));
    // ACCESS must always be preceded by SETUP, including after a completed access.
    viol_no_setup     = (phase == APB_ACCESS) &&
                        ((prev_phase_q == APB_IDLE) ||
                         ((prev_phase_q == APB_ACCESS) && prev_ready_q));

    prev_phase_d = phase;
    prev_ready_d = pready;
    prev_write_d = pwrite;
    prev_addr_d  = paddr;
    prev_wdata_d = pwdata;

    proto_err_d = proto_err_q;
    if (proto_err_clr) begin
      proto_err_d = 1'b0;
    end
    if (viol_setup_drop || viol_enable_nosel || viol_unstable || viol_no_setup) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      prev_phase_q <= APB_IDLE;
      prev_ready_q <= 1'b0;
      prev_write_q <= 1'b0;
      prev_addr_q  <= '0;
      prev_wdata_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      prev_phase_q <= prev_phase_d;
      prev_ready_q <= prev_ready_d;
      prev_write_q <= prev_write_d;
      prev_addr_q  <= prev_addr_d;
      prev_wdata_q <= prev_wdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

endmodule

// File: rtl/apb4_modport_slave.sv
// apb4_modport_slave
// APB4 completer exposing a word-addressed configuration register file with
// a fixed number of wait states per access.
// Ports:
//   pclk, preset          - clock, synchronous active-high reset
//   psel, penable, pwrite - APB control
//   paddr, pwdata         - byte address, write data
//   prdata, pready,       - read data, handshake, error (all combinational)
//   pslverr
//   hw_ro_in              - hardware values of read-only registers (slice per register)
//   reg_q                 - exported register contents (same slicing)
//   proto_err             - sticky protocol-violation flag
//   proto_err_clr         - clears proto_err
module apb4_modport_slave
  import apb4_pkg::*;
#(
  parameter int                ADDR_WIDTH  = 32,
  parameter int                DATA_WIDTH  = 32,
  parameter int                NUM_REGS    = 16,
  parameter int                WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           proto_err,
  input  logic                           proto_err_clr
);

  localparam int                IDX_W    = $clog2(NUM_REGS);
  localparam logic [WCNT_W-1:0] WAIT_CNT = WCNT_W'(WAIT_STATES);

  apb_phase_e phase;
  logic       access;

  logic [63:0]      idx_full;
  logic             legal;
  logic [IDX_W-1:0] idx;
  logic             ro_hit;

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wr_en;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  apb4_protocol_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checker (
    .pclk          (pclk),
    .preset        (preset),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .pready        (pready),
    .proto_err_clr (proto_err_clr),
    .phase         (phase),
    .proto_err     (proto_err)
  );

  assign access = (phase == APB_ACCESS);

  // Address decode: the full index is compared so that high address bits
  // beyond the register file make the access illegal rather than aliasing.
  always_comb begin
    idx_full = addr_to_index(64'(paddr), DATA_WIDTH);
    legal    = addr_aligned(64'(paddr), DATA_WIDTH) && (idx_full < 64'(NUM_REGS));
    idx      = idx_full[IDX_W-1:0];
    ro_hit   = RO_MASK[idx];
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    pready  = !preset && access && (wcnt_q == WAIT_CNT);
    pslverr = pready && (!legal || (pwrite && ro_hit));
    wr_en   = pready && pwrite && !pslverr;
    prdata  = (pready && !pwrite && legal) ? reg_view[idx] : '0;
  end

  always_comb begin
    wcnt_d = wcnt_q + WCNT_W'(1);
    if (!access || pready) begin
      wcnt_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && !RO_MASK[i] && (idx == IDX_W'(i))) begin
        regs_d[i] = pwdata;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wcnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wcnt_q <= wcnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read-only registers are seen (on the bus and on reg_q) as their hardware value.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_view
    assign reg_view[gi] = RO_MASK[gi] ? hw_ro_in[gi*DATA_WIDTH +: DATA_WIDTH] : regs_q[gi];
    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = reg_view[gi];
  end

endmodule

// File: tb/tb_apb4_modport_slave.sv
// tb_apb4_modport_slave
// Directed bench driving three completer instances:
//   dut 0: WAIT_STATES=0, no read-only registers
//   dut 1: WAIT_STATES=3, register 0 read-only
//   dut 2: WAIT_STATES=2, no read-only registers (reset during a transfer)
module tb_apb4_modport_slave;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic         preset        [3];
  logic         psel          [3];
  logic         penable       [3];
  logic         pwrite        [3];
  logic [31:0]  paddr         [3];
  logic [31:0]  pwdata        [3];
  logic [31:0]  prdata        [3];
  logic         pready        [3];
  logic         pslverr       [3];
  logic [511:0] hw_ro_in      [3];
  logic [511:0] reg_q         [3];
  logic         proto_err     [3];
  logic         proto_err_clr [3];

  int checks = 0;
  int errors = 0;

  apb4_modport_slave #(.WAIT_STATES(0), .RO_MASK(16'h0000)) dut0 (
    .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .hw_ro_in(hw_ro_in[0]), .reg_q(reg_q[0]),
    .proto_err(proto_err[0]), .proto_err_clr(proto_err_clr[0])
  );

  apb4_modport_slave #(.WAIT_STATES(3), .RO_MASK(16'h0001)) dut1 (
    .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .hw_ro_in(hw_ro_in[1]), .reg_q(reg_q[1]),
    .proto_err(proto_err[1]), .proto_err_clr(proto_err_clr[1])
  );

  apb4_modport_slave #(.WAIT_STATES(2), .RO_MASK(16'h0000)) dut2 (
    .pclk(pclk), .preset(preset[2]), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]), .hw_ro_in(hw_ro_in[2]), .reg_q(reg_q[2]),
    .proto_err(proto_err[2]), .proto_err_clr(proto_err_clr[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete SETUP + ACCESS transfer. Called at posedge+1, returns at posedge+1
  // with the bus back in IDLE. pready is checked in every ACCESS cycle.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int waits,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    for (int k = 0; k <= waits; k++) begin
      @(negedge pclk);
      chk({tag, " pready"}, 64'(pready[d]), 64'(k == waits));
      if (k == waits) begin
        chk({tag, " pslverr"}, 64'(pslverr[d]), 64'(exp_err));
        chk({tag, " prdata"}, 64'(prdata[d]), 64'(exp_rdata));
        $display("xfer dut%0d %s %s addr=%08h wdata=%08h prdata=%08h pslverr=%0b",
                 d, tag, wr ? "WR" : "RD", addr, wdata, prdata[d], pslverr[d]);
      end
      @(posedge pclk); #1;
    end
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  task automatic clr_pulse(input int d);
    proto_err_clr[d] = 1'b1;
    @(posedge pclk); #1;
    proto_err_clr[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; proto_err_clr[d] = 1'b0;
    end
    hw_ro_in[0] = {16{32'hBAD0BAD0}};
    hw_ro_in[1] = '0;
    hw_ro_in[1][31:0]  = 32'h12345678;
    hw_ro_in[1][63:32] = 32'hFFFF0000;
    hw_ro_in[2] = {16{32'h0F0F0F0F}};

    repeat (2) @(posedge pclk);
    #1;
    for (int d = 0; d < 3; d++) preset[d] = 1'b0;

    // Reset state
    @(negedge pclk);
    chk("rst reg_q0 zero", 64'(|reg_q[0]), 64'd0);
    chk("rst proto_err0", 64'(proto_err[0]), 64'd0);
    chk("rst pready0 idle", 64'(pready[0]), 64'd0);
    chk("rst reg_q1 slice0 ro", 64'(reg_q[1][31:0]), 64'h12345678);
    @(posedge pclk); #1;

    // Read every register after reset: zero, ready in the first ACCESS cycle
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, 0, 32'h0, 1'b0, $sformatf("rd_all[%0d]", i));
    end

    // Write then read back
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 0, 32'h0, 1'b0, "wr 0x08");
    chk("reg_q0 slice2 after write", 64'(reg_q[0][95:64]), 64'hDEADBEEF);
    xfer(0, 1'b0, 32'h08, 32'h0, 0, 32'hDEADBEEF, 1'b0, "rd 0x08");

    // Error writes on dut0 leave the register file alone
    xfer(0, 1'b1, 32'h40, 32'h55555555, 0, 32'h0, 1'b1, "wr 0x40 idx16");
    xfer(0, 1'b1, 32'h09, 32'h77777777, 0, 32'h0, 1'b1, "wr 0x09 unaligned");
    chk("reg_q0 slice0 after err wr", 64'(reg_q[0][31:0]), 64'h0);
    chk("reg_q0 slice2 after err wr", 64'(reg_q[0][95:64]), 64'hDEADBEEF);
    chk("proto_err0 after legal traffic", 64'(proto_err[0]), 64'd0);

    // Wait states (dut1, 3 waits)
    xfer(1, 1'b0, 32'h04, 32'h0, 3, 32'h0, 1'b0, "ws3 rd 0x04");
    xfer(1, 1'b1, 32'h04, 32'hA5A50001, 3, 32'h0, 1'b0, "ws3 wr 0x04");
    chk("reg_q1 slice1 after ws write", 64'(reg_q[1][63:32]), 64'hA5A50001);
    xfer(1, 1'b0, 32'h04, 32'h0, 3, 32'hA5A50001, 1'b0, "ws3 rd back 0x04");

    // Error cases on dut1
    xfer(1, 1'b0, 32'h41, 32'h0, 3, 32'h0, 1'b1, "rd 0x41 unaligned");
    xfer(1, 1'b1, 32'h40, 32'h99999999, 3, 32'h0, 1'b1, "wr 0x40 idx16");
    xfer(1, 1'b1, 32'h00, 32'hCCCCCCCC, 3, 32'h0, 1'b1, "wr 0x00 ro");
    xfer(1, 1'b0, 32'h00, 32'h0, 3, 32'h12345678, 1'b0, "rd 0x00 ro");
    chk("reg_q1 low slices", reg_q[1][63:0], {32'hA5A50001, 32'h12345678});
    chk("reg_q1 upper slices zero", 64'(|reg_q[1][511:64]), 64'd0);
    chk("proto_err1 legal traffic", 64'(proto_err[1]), 64'd0);

    // Protocol checker (dut0): SETUP then IDLE
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h08;
    @(posedge pclk); #1;
    psel[0] = 1'b0;
    @(posedge pclk); #1;
    chk("proto setup->idle", 64'(proto_err[0]), 64'd1);
    xfer(0, 1'b0, 32'h08, 32'h0, 0, 32'hDEADBEEF, 1'b0, "rd under proto_err");
    chk("proto sticky", 64'(proto_err[0]), 64'd1);
    clr_pulse(0);
    chk("proto cleared", 64'(proto_err[0]), 64'd0);

    // penable without psel, together with clear: set wins
    penable[0] = 1'b1; proto_err_clr[0] = 1'b1;
    @(posedge pclk); #1;
    penable[0] = 1'b0; proto_err_clr[0] = 1'b0;
    chk("proto set beats clr", 64'(proto_err[0]), 64'd1);
    clr_pulse(0);
    chk("proto cleared 2", 64'(proto_err[0]), 64'd0);

    // ACCESS entered straight from IDLE
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h0;
    @(posedge pclk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("proto idle->access", 64'(proto_err[0]), 64'd1);
    clr_pulse(0);
    chk("proto cleared 3", 64'(proto_err[0]), 64'd0);

    // Address change while stalled (dut1)
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h04;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(posedge pclk); #1;
    chk("proto stable stall", 64'(proto_err[1]), 64'd0);
    paddr[1] = 32'h08;
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    chk("proto unstable addr", 64'(proto_err[1]), 64'd1);

    // Reset in the middle of a write (dut2, 2 waits)
    xfer(2, 1'b1, 32'h10, 32'h0BADCAFE, 2, 32'h0, 1'b0, "ws2 wr 0x10");
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h0C; pwdata[2] = 32'hCAFEF00D;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset[2] = 1'b1;   // cycle where pready would otherwise rise
    @(negedge pclk);
    chk("rst pready forced", 64'(pready[2]), 64'd0);
    chk("rst pslverr forced", 64'(pslverr[2]), 64'd0);
    chk("rst prdata forced", 64'(prdata[2]), 64'd0);
    @(posedge pclk); #1;
    preset[2] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
    chk("rst no write slice3", 64'(reg_q[2][127:96]), 64'h0);
    chk("rst clears slice4", 64'(reg_q[2][159:128]), 64'h0);
    chk("rst proto_err2", 64'(proto_err[2]), 64'd0);
    xfer(2, 1'b1, 32'h0C, 32'h11223344, 2, 32'h0, 1'b0, "post-rst wr 0x0C");
    chk("post-rst slice3", 64'(reg_q[2][127:96]), 64'h11223344);
    xfer(2, 1'b0, 32'h0C, 32'h0, 2, 32'h11223344, 1'b0, "post-rst rd 0x0C");
    chk("post-rst proto_err2", 64'(proto_err[2]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
